// File: rtl/alm_eval_pkg.sv
// Shared types and helpers for the ALM error-statistics stage.
package alm_eval_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam int DWIDTH_DEF = 16;
  localparam int PROD_W     = 2*DWIDTH_DEF;
  localparam int ED_W       = PROD_W + 1;
  localparam int ACC_MAX_W  = 64;

  // Unsigned add clamped at lim; lim carries the real accumulator width.
  function automatic logic [ACC_MAX_W-1:0] sat_add(input logic [ACC_MAX_W-1:0] acc,
                                                   input logic [ACC_MAX_W-1:0] inc,
                                                   input logic [ACC_MAX_W-1:0] lim);
    logic [ACC_MAX_W:0] s;
    s = {1'b0, acc} + {1'b0, inc};
    return (s > {1'b0, lim}) ? lim : s[ACC_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/alm_err_dist.sv
// Two-stage datapath: S1 exact product, S2 error distance |z - a*b| and |a*b|.
module alm_err_dist
  import alm_eval_pkg::*;
#(
  parameter int DWIDTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       vld_i,
  input  logic signed [DWIDTH-1:0]   a_i,
  input  logic signed [DWIDTH-1:0]   b_i,
  input  logic signed [2*DWIDTH-1:0] z_i,
  output logic [2:1]                 vld_o,
  output logic [2*DWIDTH:0]          ed_o,
  output logic [2*DWIDTH-1:0]        abs_exact_o
);
  localparam int PW = 2*DWIDTH;

  logic [2:1]           vld_pipe_q;
  logic signed [PW-1:0] z_q, exact_q;
  logic [PW:0]          diff, ed_d, ed_q;
  logic [PW-1:0]        abs_d, abs_q;

  // One extra bit so the worst case (-2^31 - 2^30) does not overflow.
  assign diff  = {z_q[PW-1], z_q} - {exact_q[PW-1], exact_q};
  assign ed_d  = diff[PW] ? (~diff + 1'b1) : diff;
  assign abs_d = exact_q[PW-1] ? (~exact_q + 1'b1) : exact_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_pipe_q <= '0;
      z_q        <= '0;
      exact_q    <= '0;
      ed_q       <= '0;
      abs_q      <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[1], vld_i};
      if (vld_i) begin
        z_q     <= z_i;
        exact_q <= PW'(a_i) * PW'(b_i);
      end
      if (vld_pipe_q[1]) begin
        ed_q  <= ed_d;
        abs_q <= abs_d;
      end
    end
  end

  assign vld_o       = vld_pipe_q;
  assign ed_o        = ed_q;
  assign abs_exact_o = abs_q;

endmodule

// File: rtl/alm_error_accumulator.sv
// Run controller and saturating statistics accumulators behind alm_err_dist.
module alm_error_accumulator
  import alm_eval_pkg::*;
#(
  parameter int DWIDTH    = 16,
  parameter int ACC_WIDTH = 64,
  parameter int CNT_WIDTH = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic [CNT_WIDTH-1:0]       i_num_samples,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic signed [DWIDTH-1:0]   i_a,
  input  logic signed [DWIDTH-1:0]   i_b,
  input  logic signed [2*DWIDTH-1:0] i_z,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [ACC_WIDTH-1:0]       o_sum_ed,
  output logic [2*DWIDTH:0]          o_max_ed,
  output logic [CNT_WIDTH-1:0]       o_err_cnt,
  output logic [ACC_WIDTH-1:0]       o_sum_exact,
  output logic [CNT_WIDTH-1:0]       o_sample_cnt
);
  localparam int PW = 2*DWIDTH;
  localparam logic [ACC_MAX_W-1:0] ACC_LIM = ACC_MAX_W'({ACC_WIDTH{1'b1}});

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] n_q, n_d, issued_q, issued_d;
  logic [ACC_WIDTH-1:0] sum_ed_q, sum_ed_d, sum_ex_q, sum_ex_d;
  logic [PW:0]          max_ed_q, max_ed_d;
  logic [CNT_WIDTH-1:0] err_q, err_d, scnt_q, scnt_d;
  logic                 accept, clr;
  logic [2:1]           vld;
  logic [PW:0]          ed;
  logic [PW-1:0]        abs_ex;

  assign o_ready = (state_q == RUN) && (issued_q < n_q);
  assign accept  = i_valid && o_ready;

  alm_err_dist #(.DWIDTH(DWIDTH)) u_dist (
    .clk_i(i_clk), .rst_i(i_rst), .vld_i(accept),
    .a_i(i_a), .b_i(i_b), .z_i(i_z),
    .vld_o(vld), .ed_o(ed), .abs_exact_o(abs_ex)
  );

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    issued_d = issued_q;
    clr      = 1'b0;
    case (state_q)
      IDLE, DONE: if (i_start) begin
        n_d      = i_num_samples;
        issued_d = '0;
        clr      = 1'b1;
        state_d  = (i_num_samples == '0) ? DONE : RUN;
      end
      RUN: if (accept) begin
        issued_d = issued_q + CNT_WIDTH'(1);
        if (issued_d == n_q) state_d = DRAIN;
      end
      DRAIN: if (vld == '0) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Clear and retire never coincide: start is only taken with the pipe empty.
  always_comb begin
    sum_ed_d = sum_ed_q;
    sum_ex_d = sum_ex_q;
    max_ed_d = max_ed_q;
    err_d    = err_q;
    scnt_d   = scnt_q;
    if (clr) begin
      sum_ed_d = '0;
      sum_ex_d = '0;
      max_ed_d = '0;
      err_d    = '0;
      scnt_d   = '0;
    end else if (vld[2]) begin
      sum_ed_d = ACC_WIDTH'(sat_add(ACC_MAX_W'(sum_ed_q), ACC_MAX_W'(ed), ACC_LIM));
      sum_ex_d = ACC_WIDTH'(sat_add(ACC_MAX_W'(sum_ex_q), ACC_MAX_W'(abs_ex), ACC_LIM));
      if (ed > max_ed_q) max_ed_d = ed;
      if (ed != '0) err_d = err_q + CNT_WIDTH'(1);
      scnt_d = scnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      issued_q <= '0;
      sum_ed_q <= '0;
      sum_ex_q <= '0;
      max_ed_q <= '0;
      err_q    <= '0;
      scnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      issued_q <= issued_d;
      sum_ed_q <= sum_ed_d;
      sum_ex_q <= sum_ex_d;
      max_ed_q <= max_ed_d;
      err_q    <= err_d;
      scnt_q   <= scnt_d;
    end
  end

  assign o_busy       = (state_q == RUN) || (state_q == DRAIN);
  assign o_done       = (state_q == DONE);
  assign o_sum_ed     = sum_ed_q;
  assign o_max_ed     = max_ed_q;
  assign o_err_cnt    = err_q;
  assign o_sum_exact  = sum_ex_q;
  assign o_sample_cnt = scnt_q;

endmodule
